inst_fetch: RTL

- Instruction fetch stage directly upstream of the main control decoder.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Registers the returned word and presents it with its opcode field op_code[5:0] to the decoder.
- Computes the next PC from the branch/jump/zero decision returned by the core when the instruction retires.

---
 rtl/inst_fetch.sv | 104 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/ready handshake, and presents the held instruction to the main decoder.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [5:0]  BUBBLE_OP = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] retired_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] branch_off_s;
    logic [31:0] next_pc_s;

    assign pc_plus4_s   = pc_r + 32'd4;
    assign branch_off_s = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};

    // Handshake sequencing: wait for the word, then wait for retirement.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (imem_ready) begin
                    state_next_s = VALID;
                end else begin
                    state_next_s = FETCH;
                end
            end
            VALID: begin
                if (advance) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = VALID;
                end
            end
            default: state_next_s = FETCH;
        endcase
    end

    // Next PC selection; jump takes priority over a taken branch.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (jump) begin
            next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc_s = pc_plus4_s + branch_off_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // State, held instruction, PC and retirement counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= FETCH;
            pc_r      <= RESET_PC;
            instr_r   <= 32'h0000_0000;
            retired_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if ((state_r == FETCH) && imem_ready) begin
                instr_r <= imem_rdata;
            end
            if ((state_r == VALID) && advance) begin
                pc_r      <= next_pc_s;
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    assign imem_req    = (state_r == FETCH);
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = (state_r == VALID);
    assign op_code     = (state_r == VALID) ? instr_r[31:26] : BUBBLE_OP;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign retired     = retired_r;

endmodule
